uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/rx_pulse_sync.sv | 24 ++
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and parameter helpers
package uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_DATA_W     = 8;

    localparam logic [7:0] RXD_ADDR      = 8'h00;
    localparam logic [7:0] UART_CON_ADDR = 8'h04;

    function automatic bit is_pow2(input int n);
        return (n > 1) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rx_pulse_sync.sv
// rtl/rx_pulse_sync.sv - two-flop synchronizer plus rising-edge pulse for the receiver byte-done level
module rx_pulse_sync (
    input  logic sysclk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       edge_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], level_i};
            edge_q <= sync_q[1];
        end
    end

    assign pulse_o = sync_q[1] & ~edge_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO, first-word-fall-through; irq logic enabled by UART_RX_FIFO_IRQ_EN
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_FIFO_DEPTH,
    parameter int DATA_W    = UART_DATA_W,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     rx_status,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     pop,
    input  logic                     clr,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (!is_pow2(DEPTH) || DEPTH > 256) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
    end
    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
        $error("uart_rx_fifo: IRQ_LEVEL must be in 1..DEPTH");
    end

    logic              push;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              do_pop, do_write;

    rx_pulse_sync u_sync (
        .sysclk  (sysclk),
        .reset   (reset),
        .level_i (rx_status),
        .pulse_o (push)
    );

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

    // A push into a full FIFO only lands when a pop frees the head slot in the same cycle.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        do_pop     = pop & ~empty;
        do_write   = 1'b0;
        if (clr) begin
            wptr_d     = '0;
            rptr_d     = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            do_pop     = 1'b0;
        end else begin
            do_write = push & (~full | do_pop);
            if (push && full && !do_pop) begin
                overflow_d = 1'b1;
            end
            if (do_write) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({do_write, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset && do_write) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

    assign dout     = empty ? '0 : mem_q[rptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = (level_q >= LW'(IRQ_LEVEL)) | overflow_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
